// File: rtl/pc_ctrl_rv32i.sv
// Program-counter controller at the head of RV32I fetch: sequential increment,
// stall hold, branch redirect with alignment check, trap entry/return and double-fault halt.
module pc_ctrl_rv32i #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              ALIGN        = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [3:0]      trap_cause,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic [3:0]      mcause,
  output logic            flush,
  output logic            in_handler,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [3:0]      mcause_q, mcause_d;
  logic            flush_q, flush_d;
  logic            misalign;
  logic            fault;

  // A target is misaligned when any of its low ALIGN bits are set; ALIGN = 0 accepts any byte address.
  generate
    if (ALIGN == 0) begin : g_no_align
      assign misalign = 1'b0;
    end else begin : g_align
      assign misalign = br_taken & (br_target[ALIGN-1:0] != '0);
    end
  endgenerate

  assign fault    = trap | misalign;
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    mcause_d = mcause_q;
    flush_d  = 1'b0;

    if (state_q == ST_HALT) begin
      // Terminal until reset.
    end else if (fault && state_q == ST_RUN) begin
      epc_d    = pc_q;
      mcause_d = trap ? trap_cause : 4'd0;
      pc_d     = TRAP_VECTOR;
      state_d  = ST_HANDLER;
      flush_d  = 1'b1;
    end else if (fault) begin
      // A fault inside the handler is a double fault; pc and capture registers freeze.
      state_d = ST_HALT;
      flush_d = 1'b1;
    end else if (mret && state_q == ST_HANDLER) begin
      pc_d    = epc_q;
      state_d = ST_RUN;
      flush_d = 1'b1;
    end else if (stall) begin
      // A concurrent br_taken is dropped; upstream re-presents it.
    end else if (br_taken) begin
      pc_d    = br_target;
      flush_d = 1'b1;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // NOTE: reset clears only control/architectural registers here; there is no memory array,
  // so every flop has a defined reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      epc_q    <= '0;
      mcause_q <= 4'd0;
      flush_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      mcause_q <= mcause_d;
      flush_q  <= flush_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign mcause     = mcause_q;
  assign flush      = flush_q;
  assign in_handler = (state_q == ST_HANDLER);
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_ctrl_rv32i.sv
// Self-checking bench for pc_ctrl_rv32i: directed vector table, hand-written
// async-reset / wrap / misalign sequences, then randomized traffic against a reference model.
module tb_pc_ctrl_rv32i;

  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, trap, mret;
  logic [31:0] br_target;
  logic [3:0]  trap_cause;
  logic [31:0] pc, pc_plus4, epc;
  logic [3:0]  mcause;
  logic        flush, in_handler, halted;

  int n_checks = 0;
  int n_fail   = 0;

  pc_ctrl_rv32i #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .ALIGN(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .trap(trap), .trap_cause(trap_cause), .mret(mret), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .mcause(mcause), .flush(flush), .in_handler(in_handler), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic tr, input logic [3:0] c, input logic m);
    stall = s; br_taken = b; br_target = t; trap = tr; trap_cause = c; mret = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall, br, trap, mret;
    logic [31:0] tgt;
    logic [3:0]  cause;
    logic [31:0] e_pc, e_epc;
    logic [3:0]  e_mc;
    logic        e_flush, e_inh, e_halt;
  } vec_t;

  vec_t tbl[19];

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_cause;
  logic        m_flush, m_in_handler, m_halted;

  task automatic model_reset();
    m_pc = RV; m_epc = 0; m_cause = 0; m_flush = 0; m_in_handler = 0; m_halted = 0;
  endtask

  // One clock edge, using the inputs currently applied.
  task automatic model_edge();
    bit mis, fault;
    mis   = br_taken && (br_target % 4 != 0);
    fault = trap || mis;
    if (m_halted) begin
      m_flush = 0;
    end else if (fault && !m_in_handler) begin
      m_epc = m_pc; m_cause = trap ? trap_cause : 4'd0;
      m_pc = TV; m_in_handler = 1; m_flush = 1;
    end else if (fault) begin
      m_halted = 1; m_in_handler = 0; m_flush = 1;
    end else if (mret && m_in_handler) begin
      m_pc = m_epc; m_in_handler = 0; m_flush = 1;
    end else if (stall) begin
      m_flush = 0;
    end else if (br_taken) begin
      m_pc = br_target; m_flush = 1;
    end else begin
      m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000); m_flush = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"},         pc,         m_pc);
    check({tag, ".pc_plus4"},   pc_plus4,   32'((longint'(m_pc) + 4) % 64'h1_0000_0000));
    check({tag, ".epc"},        epc,        m_epc);
    check({tag, ".mcause"},     mcause,     m_cause);
    check({tag, ".flush"},      flush,      m_flush);
    check({tag, ".in_handler"}, in_handler, m_in_handler);
    check({tag, ".halted"},     halted,     m_halted);
  endtask

  initial begin
    //            stall br trap mret tgt            cause  e_pc          e_epc         mc    f  inh hlt
    tbl[0]  = '{0, 0, 0, 0, 32'h0,          4'h0, 32'h0000_1004, 32'h0,        4'h0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 32'h0,          4'h0, 32'h0000_1008, 32'h0,        4'h0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 32'h0000_C000,  4'h0, 32'h0000_C000, 32'h0,        4'h0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 32'h0000_D000,  4'h0, 32'h0000_C000, 32'h0,        4'h0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,          4'h0, 32'h0000_C004, 32'h0,        4'h0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 32'h0000_C006,  4'h0, 32'h0000_0100, 32'h0000_C004, 4'h0, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 32'h0,          4'h0, 32'h0000_C004, 32'h0000_C004, 4'h0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 32'h0000_2000,  4'h0, 32'h0000_2000, 32'h0000_C004, 4'h0, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 32'h0,          4'hB, 32'h0000_0100, 32'h0000_2000, 4'hB, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 32'h0,          4'h0, 32'h0000_0104, 32'h0000_2000, 4'hB, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 32'h0,          4'h0, 32'h0000_2000, 32'h0000_2000, 4'hB, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 32'h0,          4'h0, 32'h0000_2000, 32'h0000_2000, 4'hB, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 32'h0,          4'h3, 32'h0000_0100, 32'h0000_2000, 4'h3, 1, 1, 0};
    tbl[13] = '{0, 0, 1, 0, 32'h0,          4'h5, 32'h0000_0100, 32'h0000_2000, 4'h3, 1, 0, 1};
    tbl[14] = '{0, 1, 0, 0, 32'h0000_C000,  4'h0, 32'h0000_0100, 32'h0000_2000, 4'h3, 0, 0, 1};
    tbl[15] = '{0, 0, 1, 0, 32'h0,          4'h7, 32'h0000_0100, 32'h0000_2000, 4'h3, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 1, 32'h0,          4'h0, 32'h0000_0100, 32'h0000_2000, 4'h3, 0, 0, 1};
    tbl[17] = '{1, 1, 0, 0, 32'h0000_0002,  4'h0, 32'h0000_0100, 32'h0000_2000, 4'h3, 0, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 32'h0,          4'h0, 32'h0000_0100, 32'h0000_2000, 4'h3, 0, 0, 1};

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 4'h0, 0);
    repeat (2) tick();
    check("reset.pc", pc, RV);
    check("reset.flush", flush, 1'b0);
    check("reset.epc", epc, 32'h0);
    check("reset.mcause", mcause, 4'h0);
    check("reset.in_handler", in_handler, 1'b0);
    check("reset.halted", halted, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].trap, tbl[i].cause, tbl[i].mret);
      tick();
      check($sformatf("vec%0d.pc", i),         pc,         tbl[i].e_pc);
      check($sformatf("vec%0d.pc_plus4", i),   pc_plus4,   tbl[i].e_pc + 32'd4);
      check($sformatf("vec%0d.epc", i),        epc,        tbl[i].e_epc);
      check($sformatf("vec%0d.mcause", i),     mcause,     tbl[i].e_mc);
      check($sformatf("vec%0d.flush", i),      flush,      tbl[i].e_flush);
      check($sformatf("vec%0d.in_handler", i), in_handler, tbl[i].e_inh);
      check($sformatf("vec%0d.halted", i),     halted,     tbl[i].e_halt);
    end

    // Async reset pulse between edges while halted: clears without a clock edge.
    drive(0, 0, 32'h0, 0, 4'h0, 0);
    #3 reset = 1'b1;
    #1;
    check("async_rst.pc", pc, RV);
    check("async_rst.halted", halted, 1'b0);
    check("async_rst.epc", epc, 32'h0);
    check("async_rst.mcause", mcause, 4'h0);
    #1 reset = 1'b0;
    tick();
    check("post_rst.pc", pc, RV + 32'd4);
    check("post_rst.flush", flush, 1'b0);

    // Back-to-back redirects keep flush high, then wrap-around at the top of the space.
    drive(0, 1, 32'h0000_3000, 0, 4'h0, 0);
    tick();
    check("b2b0.flush", flush, 1'b1);
    drive(0, 1, 32'hFFFF_FFFC, 0, 4'h0, 0);
    tick();
    check("b2b1.flush", flush, 1'b1);
    check("wrap.pc", pc, 32'hFFFF_FFFC);
    check("wrap.pc_plus4", pc_plus4, 32'h0000_0000);
    drive(0, 0, 32'h0, 0, 4'h0, 0);
    tick();
    check("wrap_next.pc", pc, 32'h0000_0000);
    check("wrap_next.flush", flush, 1'b0);
    tick();
    check("wrap_next2.pc", pc, 32'h0000_0004);

    // Low-bit misalignment (bit 0 only) still faults.
    drive(0, 1, 32'h0000_3001, 0, 4'h0, 0);
    tick();
    check("mis_b0.pc", pc, TV);
    check("mis_b0.epc", epc, 32'h0000_0004);
    check("mis_b0.mcause", mcause, 4'h0);
    check("mis_b0.in_handler", in_handler, 1'b1);
    // Misaligned target while in the handler is a double fault.
    drive(0, 1, 32'h0000_0102, 0, 4'h0, 0);
    tick();
    check("mis_dbl.halted", halted, 1'b1);
    check("mis_dbl.pc", pc, TV);
    check("mis_dbl.flush", flush, 1'b1);

    // ---------------- randomized phase ----------------
    drive(0, 0, 32'h0, 0, 4'h0, 0);
    #3 reset = 1'b1;
    #1 model_reset();
    compare_model("rnd_rst");
    #1 reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] t;
      int r;
      r = $urandom_range(0, 99);
      t = {$urandom(), 2'b00} >> 0;
      t[1:0] = 2'b00;
      if (r < 10) t[1:0] = 2'($urandom_range(1, 3));
      else if (r < 15) t = 32'hFFFF_FFFC;
      drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30, t,
            $urandom_range(0, 99) < 5, 4'($urandom()), $urandom_range(0, 99) < 20);
      @(posedge clk);
      model_edge();
      #1;
      compare_model($sformatf("rnd%0d", c));
      if ((m_halted && $urandom_range(0, 99) < 30) || (c % 97 == 96)) begin
        #3 reset = 1'b1;
        #1 model_reset();
        compare_model($sformatf("rnd%0d_rst", c));
        #1 reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
